// File: rtl/semi_auto_nav_fsm_if.sv
// Command/detector/motor bundle for the semi-automatic navigation controller.
//   slave  : the controller (consumes detectors + commands, drives motion/status)
//   master : the front-end / motor side (drives detectors + commands)
// Signals:
//   front/left/right_detector        raw wall sensors, 1 = wall present
//   go_straight/turn_left/turn_right/u_turn_command  level commands
//   move_forward/turn_left/turn_right_signal          motor drive
//   state[2:0], busy, done_pulse                      status
interface semi_auto_nav_fsm_if;
  logic       front_detector;
  logic       left_detector;
  logic       right_detector;
  logic       go_straight_command;
  logic       turn_left_command;
  logic       turn_right_command;
  logic       u_turn_command;
  logic       move_forward_signal;
  logic       turn_left_signal;
  logic       turn_right_signal;
  logic [2:0] state;
  logic       busy;
  logic       done_pulse;

  modport slave (
    input  front_detector, left_detector, right_detector,
    input  go_straight_command, turn_left_command, turn_right_command, u_turn_command,
    output move_forward_signal, turn_left_signal, turn_right_signal,
    output state, busy, done_pulse
  );

  modport master (
    output front_detector, left_detector, right_detector,
    output go_straight_command, turn_left_command, turn_right_command, u_turn_command,
    input  move_forward_signal, turn_left_signal, turn_right_signal,
    input  state, busy, done_pulse
  );
endinterface

// File: rtl/semi_auto_nav_fsm.sv
// Semi-automatic driving controller.
// Accepts a one-hot command in WAIT, runs a timed turn / U-turn, a forced
// forward settle phase, then drives forward while the debounced detectors
// report a corridor (front clear, walls left and right).
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  semi_auto_nav_fsm_if.slave (detectors, commands, motion, status)
module semi_auto_nav_fsm #(
  parameter int TURN_CYCLES     = 1_000_000,
  parameter int SETTLE_CYCLES   = 500_000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  semi_auto_nav_fsm_if.slave   bus
);

  typedef enum logic [2:0] {
    WAIT   = 3'b000,
    MOVE   = 3'b001,
    SETTLE = 3'b010,
    TURN_L = 3'b011,
    TURN_R = 3'b100,
    U_TURN = 3'b101
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] UTURN_LAST  = CNT_W'(2 * TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       CORRIDOR    = 3'b011;

  // ---------------- detector debounce, {front, left, right} ----------------
  logic [2:0] raw, filt;
  assign raw = {bus.front_detector, bus.left_detector, bus.right_detector};

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            f;
    // The counter counts consecutive samples that disagree with the filtered
    // bit; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
        f   <= 1'b0;
      end else if (raw[g] == f) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        f   <= raw[g];
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
    assign filt[g] = f;
  end

  // ---------------- control FSM ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [3:0]       cmd;

  assign cmd = {bus.go_straight_command, bus.turn_left_command,
                bus.turn_right_command, bus.u_turn_command};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    done_d  = 1'b0;
    case (state_q)
      WAIT: begin
        cnt_d = '0;
        // Only an exactly-one-hot command is accepted.
        case (cmd)
          4'b1000: state_d = SETTLE;
          4'b0100: state_d = TURN_L;
          4'b0010: state_d = TURN_R;
          4'b0001: state_d = U_TURN;
          default: state_d = WAIT;
        endcase
      end
      TURN_L, TURN_R: begin
        if (cnt_q == TURN_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      U_TURN: begin
        if (cnt_q == UTURN_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = MOVE;
          cnt_d   = '0;
        end
      end
      MOVE: begin
        cnt_d = '0;
        if (filt != CORRIDOR) begin
          state_d = WAIT;
          done_d  = 1'b1;
        end
      end
      default: begin
        // unused codes recover to WAIT
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------- Moore outputs ----------------
  assign bus.state               = state_q;
  assign bus.busy                = (state_q != WAIT);
  assign bus.done_pulse          = done_q;
  assign bus.move_forward_signal = (state_q == MOVE) || (state_q == SETTLE);
  assign bus.turn_left_signal    = (state_q == TURN_L);
  assign bus.turn_right_signal   = (state_q == TURN_R) || (state_q == U_TURN);

endmodule

// File: doc/semi_auto_nav_fsm.md
Name: semi_auto_nav_fsm

Overview:
Parametrised next-generation semi-automatic driving controller. It sits between the command buttons/detector front-end and the motor-drive block. It accepts a one-hot driving command while idle, executes timed turns, a U-turn, and a post-turn settle phase, then drives forward until the debounced detectors show the car has left a corridor. All timing and the detector filter depth are parameters, and it reports completion and status.

Parameters:
TURN_CYCLES, 1_000_000, clk cycles a 90-degree turn is held (U-turn holds 2*TURN_CYCLES)
SETTLE_CYCLES, 500_000, clk cycles of forced forward drive after any command, detectors ignored
DEBOUNCE_CYCLES, 16, consecutive identical raw samples needed before a filtered detector bit changes (>=1)
CNT_W, 32, width of the shared phase counter; must hold 2*TURN_CYCLES and SETTLE_CYCLES

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-low reset
front_detector  input  1  raw: 1 = wall ahead
left_detector  input  1  raw: 1 = wall on left
right_detector  input  1  raw: 1 = wall on right
go_straight_command  input  1  level command
turn_left_command  input  1  level command
turn_right_command  input  1  level command
u_turn_command  input  1  level command
move_forward_signal  output  1  drive forward
turn_left_signal  output  1  rotate left
turn_right_signal  output  1  rotate right
state  output  3  current FSM state
busy  output  1  1 whenever state != WAIT
done_pulse  output  1  one-cycle pulse on MOVE->WAIT

Behaviour:
- Reset (rst=0, async): state=WAIT, phase counter=0, filtered detectors=3'b000, debounce counters=0, all outputs 0. Release takes effect on the next clk edge.
- State encoding: WAIT=000, MOVE=001, SETTLE=010, TURN_L=011, TURN_R=100, U_TURN=101. Codes 110/111 go to WAIT on the next edge.
- Outputs are a Moore decode of the state register. WAIT: 000. MOVE/SETTLE: forward=1. TURN_L: left=1. TURN_R/U_TURN: right=1. At most one motion output is high at any time.
- WAIT: the phase counter is cleared. Commands are sampled only in WAIT, as a 4-bit one-hot {straight, left, right, u_turn}.
  - straight->SETTLE, left->TURN_L, right->TURN_R, u_turn->U_TURN.
  - Zero or multiple commands asserted: stay in WAIT.
  - Commands asserted outside WAIT are ignored.
- TURN_L/TURN_R: the counter increments each cycle. When count==TURN_CYCLES-1, go to SETTLE and clear the counter. The turn output is high for exactly TURN_CYCLES cycles.
- U_TURN: same as a turn, with the limit 2*TURN_CYCLES-1.
- SETTLE: forward for exactly SETTLE_CYCLES cycles, then MOVE with the counter cleared. Detectors are ignored.
- MOVE: stay while filtered {front,left,right}==3'b011 (corridor). Any other pattern means WAIT on the next edge, and done_pulse=1 in that same cycle as the WAIT entry (registered, one cycle). This includes front wall (1xx), an opening (x0x/xx0), and dead end 111.
- Debounce: one counter per detector. When the raw bit differs from the filtered bit, its counter increments; at DEBOUNCE_CYCLES-1 the filtered bit takes the raw value and the counter clears. When the raw bit equals the filtered bit, the counter clears. With DEBOUNCE_CYCLES=1, filtered equals raw delayed by one cycle. The filter runs in all states.
- Counter arithmetic is unsigned, CNT_W bits, and never wraps under legal parameters.
- Simultaneous events: a command present on the same edge the FSM enters WAIT is not acted on; it is sampled from the following cycle.
- Reset mid-turn or mid-move: immediate WAIT with outputs 0; no done_pulse.

Test Plan:
Use TURN_CYCLES=4, SETTLE_CYCLES=3, DEBOUNCE_CYCLES=2 for all scenarios.
1. Reset then turn_left_command=1 for 1 cycle -> turn_left_signal high exactly 4 cycles, then forward 3 cycles (SETTLE), then state=001.
2. u_turn_command pulse -> turn_right_signal high exactly 8 cycles, state=101 throughout, then SETTLE 3 cycles.
3. In MOVE with detectors 011 steady, left_detector drops to 0 for 1 cycle -> no exit; drops for 2 cycles -> state=000 one cycle after filter update, done_pulse high 1 cycle, outputs 000.
4. In WAIT, turn_left and turn_right asserted together -> state stays 000 with outputs 000; then go_straight alone -> SETTLE 3 cycles then MOVE.
5. Turn_right_command held high during TURN_R and SETTLE -> ignored; after MOVE->WAIT with the command still high -> new TURN_R starts one cycle after WAIT entry.
6. rst asserted low mid-TURN_L (count=2) -> outputs 0 and state=000 immediately without a clk edge; after release, a left command gives a full 4-cycle turn.
